mul_seq_unit: RTL and testbench
===============================

// Module: mul_seq_unit
// PURPOSE
//   Sequential 32x32 multiplier for the MIPS54 core: the multiply counterpart of the divide unit.
//   It serves MULTU, and MULT when MULT_SIGNED_EN is defined.
//   It uses a radix-2 shift-add datapath, one multiplier bit per cycle, with a start/busy handshake.
//   The 64-bit product is written to the HI/LO registers: hi = product[63:32], lo = product[31:0].
// PARAMETERS
//   WIDTH   32   operand width; product is 2*WIDTH; iteration count = WIDTH
// PORTS
//   clock      in   1        single clock; all state updates on posedge
//   reset      in   1        asynchronous, active-high; clears all state
//   start      in   1        one-cycle request; sampled only when busy==0
//   is_signed  in   1        1 = MULT, 0 = MULTU (honoured only with MULT_SIGNED_EN)
//   a          in   WIDTH    multiplicand, sampled with start
//   b          in   WIDTH    multiplier, sampled with start
//   busy       out  1        high while iterating
//   done       out  1        one-cycle pulse when hi/lo become valid
//   hi         out  WIDTH    product[63:32]
//   lo         out  WIDTH    product[31:0]
// BEHAVIOUR
//   Reset: busy=0, done=0, hi=0, lo=0, count=0, FSM=IDLE; this applies immediately, mid-operation included.
//   FSM states:
//     IDLE -> RUN on posedge with start=1; a and b are latched; acc=0; count=0; busy<=1.
//     RUN: each posedge, if the multiplier LSB is 1, add the multiplicand to the accumulator upper half.
//       The add is 33 bits wide, and the carry is kept.
//       Then shift {carry, acc, mplr} right by 1 and increment count.
//     RUN -> IDLE on the edge where count==WIDTH-1: busy<=0, done<=1, hi/lo<=final product.
//   Latency: start sampled at edge E0; busy is high after E0 through E31; done is high for the cycle after E32.
//     Total = WIDTH cycles of busy; the next start is accepted on the edge where done==1.
//   done is high for exactly one cycle, and is low in every cycle except the one following completion.
//   hi/lo hold their value until the next completion; they are NOT cleared on start.
//     Intermediate accumulator bits never appear on hi/lo.
//   start while busy==1 is ignored: operands are not relatched and the count is not restarted.
//   Operands of 0 still take the full WIDTH cycles; there is no early termination.
//   Arithmetic: unsigned product is exact, so hi:lo = a*b mod 2^64 is never truncated.
// CONFIGURATION
//   MULT_SIGNED_EN defined:
//     When is_signed=1, a and b are converted to magnitudes when latched.
//     The sign = a[31]^b[31] is stored.
//     At completion, the 64-bit result is negated (two's complement) if the sign is set, in the same edge as done.
//     0x80000000*0x80000000 gives 0x40000000_00000000.
//   MULT_SIGNED_EN undefined:
//     is_signed is ignored and all multiplies are unsigned; the magnitude/negate logic is absent.
// TESTING
//   1. a=3, b=5, start 1 cycle -> busy for 32 cycles; done pulse; hi=0, lo=15.
//   2. a=b=0xFFFFFFFF unsigned -> hi=0xFFFFFFFE, lo=0x00000001; latency exactly 32 cycles start-to-done.
//   3. Start pulses again at busy cycle 10 with a=7, b=7 -> ignored; original result delivered at cycle 32; hi/lo not 49.
//   4. Reset asserted at busy cycle 16 -> busy, done, hi and lo all 0 asynchronously.
//      Then a=2, b=9 completes with lo=18.
//   5. Back-to-back: start on the done cycle with a=0x10000, b=0x10000 -> busy next cycle; hi=1, lo=0 after 32 cycles.
//   6. (MULT_SIGNED_EN) is_signed=1, a=-3 (0xFFFFFFFD), b=4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
//      The same inputs with is_signed=0 -> hi=0x00000003, lo=0xFFFFFFF4.

Source files
------------

// File: rtl/mul_seq_unit.sv
// mul_seq_unit: sequential radix-2 shift-add 32x32 multiplier for HI/LO.
// One multiplier bit is consumed per cycle, behind a start/busy/done handshake.
// Optional feature macro: MULT_SIGNED_EN (enables MULT signed handling via is_signed).
module mul_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    result;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef MULT_SIGNED_EN
    logic sign;
    logic sign_in;

    // Operand magnitudes and result sign for MULT; MULTU passes operands through.
    always_comb begin
        sign_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        mag_a   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        mag_b   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;

    // All multiplies are unsigned in this build.
    always_comb begin
        mag_a = a;
        mag_b = b;
    end
`endif

    // 33-bit conditional add with carry kept, and the product as it stands after this step.
    always_comb begin
        sum  = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod = {sum, mplr[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
        result = sign ? (~prod + PW'(1)) : prod;
`else
        result = prod;
`endif
    end

    // Control FSM and datapath registers; hi/lo only ever receive the final product.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            mcand <= '0;
            acc   <= '0;
            mplr  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
`ifdef MULT_SIGNED_EN
            sign  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= mag_a;
                        mplr  <= mag_b;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef MULT_SIGNED_EN
                        sign  <= sign_in;
`endif
                    end
                end
                RUN: begin
                    acc   <= sum[WIDTH:1];
                    mplr  <= {sum[0], mplr[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= result[PW-1:WIDTH];
                        lo    <= result[WIDTH-1:0];
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Testbench for mul_seq_unit: vector table, randomized operands against an
// arithmetic reference model, and hand-written handshake corner sequences.
module tb_mul_seq_unit;

`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mul_seq_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operands as the ISA defines them.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        if (s && SIGNED_EN) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return 64'(ux * uy);
    endfunction

    // One multiply transaction; inj>0 pulses a stray start (7*7) at that busy cycle.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input bit b2b, input int inj, input logic [63:0] exp, input string nm);
        logic [31:0] h0;
        logic [31:0] l0;
        int          lat;
        int          busy_cyc;
        int          hold_bad;
        bit          got;
        if (!b2b) begin
            @(posedge clock);
            #1;
        end
        h0 = hi;
        l0 = lo;
        a = ia;
        b = ib;
        is_signed = is;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        chk({nm, "_busy_after_start"}, 64'(busy), 64'd1);
        chk({nm, "_done_low_at_start"}, 64'(done), 64'd0);
        lat = 0;
        busy_cyc = 0;
        hold_bad = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            if (busy) busy_cyc++;
            if (busy && (hi !== h0 || lo !== l0)) hold_bad++;
            if (done) hold_bad++;
            if (inj > 0 && lat + 1 == inj) begin
                start = 1'b1;
                a = 32'd7;
                b = 32'd7;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            lat++;
            if (done) got = 1'b1;
        end
        chk({nm, "_done_seen"}, 64'(got), 64'd1);
        chk({nm, "_latency"}, 64'(lat), 64'd32);
        chk({nm, "_busy_cycles"}, 64'(busy_cyc), 64'd32);
        chk({nm, "_busy_low_at_done"}, 64'(busy), 64'd0);
        chk({nm, "_hilo_held"}, 64'(hold_bad), 64'd0);
        chk({nm, "_result"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [31:0] edge_ops[6];

        vt[0] = '{32'd3,        32'd5,        1'b0, 64'd15};
        vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        vt[2] = '{32'd0,        32'hFFFFFFFF, 1'b0, 64'd0};
        vt[3] = '{32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000};
        vt[4] = '{32'hFFFFFFFD, 32'd4,        1'b0, 64'h00000003_FFFFFFF4};
        vt[5] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        vt[6] = '{32'hFFFFFFFD, 32'd4,        1'b1,
                  SIGNED_EN ? 64'hFFFFFFFF_FFFFFFF4 : 64'h00000003_FFFFFFF4};
        vt[7] = '{32'hFFFFFFFF, 32'd1,        1'b1,
                  SIGNED_EN ? 64'hFFFFFFFF_FFFFFFFF : 64'h00000000_FFFFFFFF};

        edge_ops[0] = 32'h0;
        edge_ops[1] = 32'h1;
        edge_ops[2] = 32'hFFFFFFFF;
        edge_ops[3] = 32'h80000000;
        edge_ops[4] = 32'h7FFFFFFF;
        edge_ops[5] = 32'h80000001;

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 8; i++)
            do_op(vt[i].a, vt[i].b, vt[i].s, 1'b0, 0, vt[i].exp, $sformatf("vec%0d", i));

        // Stray start at busy cycle 10 must be ignored
        do_op(32'd3, 32'd5, 1'b0, 1'b0, 10, 64'd15, "ignore_start");

        // Back-to-back start on the done cycle
        do_op(32'h00010000, 32'h00010000, 1'b0, 1'b1, 0, 64'h00000001_00000000, "b2b");

        // Asynchronous reset mid-operation
        @(posedge clock);
        #1;
        a = 32'h12345678;
        b = 32'h9ABCDEF0;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        do_op(32'd2, 32'd9, 1'b0, 1'b0, 0, 64'd18, "after_rst");

        // Randomized operands against the model
        for (int i = 0; i < 24; i++) begin
            ra = (i % 4 == 0) ? edge_ops[$urandom_range(0, 5)] : 32'($urandom);
            rb = (i % 3 == 0) ? edge_ops[$urandom_range(0, 5)] : 32'($urandom);
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, (i % 5 == 4), 0, model(ra, rb, rs), $sformatf("rnd%0d", i));
        end

        // done must fall after its single-cycle pulse
        @(posedge clock);
        #1;
        chk("done_pulse_width", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
